// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the control_unit sequencer.
// Instruction byte layout: [7:4] class, [3:0] field f.
package ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        IWAIT,
        DECODE,
        EXEC1,
        EXEC2,
        MWAIT,
        HALT
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ALU  = 4'h1;
    localparam logic [3:0] OP_LDR  = 4'h2;
    localparam logic [3:0] OP_STR  = 4'h3;
    localparam logic [3:0] OP_LDM  = 4'h4;
    localparam logic [3:0] OP_STM  = 4'h5;
    localparam logic [3:0] OP_JMP  = 4'h6;
    localparam logic [3:0] OP_JMPN = 4'h7;
    localparam logic [3:0] OP_JMPL = 4'h8;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [3:0] BUS_AC   = 4'hA;
    localparam logic [3:0] BUS_ALU  = 4'hB;
    localparam logic [3:0] BUS_DRAM = 4'hC;

    localparam logic [3:0] ALU_NOP = 4'h0;

    function automatic logic is_defined(input logic [3:0] cls);
        return (cls <= OP_JMPL) || (cls == OP_HALT);
    endfunction

    // Classes whose field names a general register and must be range-checked.
    function automatic logic uses_reg_field(input logic [3:0] cls);
        return (cls == OP_LDR) || (cls == OP_STR) || (cls == OP_JMP) ||
               (cls == OP_JMPN) || (cls == OP_JMPL);
    endfunction

endpackage

// File: rtl/control_unit_if.sv
// Datapath-facing signal bundle of the control_unit sequencer.
// master = sequencer side, slave = datapath/memory side.
interface control_unit_if #(
    parameter int NREG = 8
);
    logic [7:0]      iram_data;
    logic            neg;
    logic            lsb;
    logic            iram_rd;
    logic            pc_inc;
    logic            pc_ld;
    logic [3:0]      alu_sel;
    logic [3:0]      bus_sel;
    logic            ac_we;
    logic [NREG-1:0] reg_we;
    logic            dram_rd;
    logic            dram_we;
    logic            halt;
    logic            illegal;

    modport master (
        input  iram_data, neg, lsb,
        output iram_rd, pc_inc, pc_ld, alu_sel, bus_sel, ac_we, reg_we,
               dram_rd, dram_we, halt, illegal
    );

    modport slave (
        output iram_data, neg, lsb,
        input  iram_rd, pc_inc, pc_ld, alu_sel, bus_sel, ac_we, reg_we,
               dram_rd, dram_we, halt, illegal
    );
endinterface

// File: rtl/ctrl_decode.sv
// Moore output decode for control_unit: maps (state, IR, latched flags)
// to every strobe and select; purely combinational.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int NREG = 8
) (
    input  state_t          state,
    input  logic [7:0]      ir,
    input  logic            neg_q,
    input  logic            lsb_q,
    input  logic            mem_done,
    output logic            iram_rd,
    output logic            pc_inc,
    output logic            pc_ld,
    output logic [3:0]      alu_sel,
    output logic [3:0]      bus_sel,
    output logic            ac_we,
    output logic [NREG-1:0] reg_we,
    output logic            dram_rd,
    output logic            dram_we,
    output logic            halt,
    output logic            illegal
);
    logic [3:0] cls;
    logic [3:0] f;
    logic       field_ok;

    assign cls      = ir[7:4];
    assign f        = ir[3:0];
    assign field_ok = ({1'b0, f} < 5'(NREG));

    always_comb begin
        iram_rd = 1'b0;
        pc_inc  = 1'b0;
        pc_ld   = 1'b0;
        alu_sel = ALU_NOP;
        bus_sel = 4'h0;
        ac_we   = 1'b0;
        reg_we  = '0;
        dram_rd = 1'b0;
        dram_we = 1'b0;
        halt    = 1'b0;
        illegal = 1'b0;
        case (state)
            FETCH: begin
                iram_rd = 1'b1;
                pc_inc  = 1'b1;
            end
            DECODE: illegal = !is_defined(cls);
            EXEC1: begin
                // A bad register field suppresses every write/load strobe.
                if (uses_reg_field(cls) && !field_ok) begin
                    illegal = 1'b1;
                end else begin
                    case (cls)
                        OP_ALU: alu_sel = f;
                        OP_LDR: begin
                            bus_sel = f;
                            ac_we   = 1'b1;
                        end
                        OP_STR: begin
                            bus_sel = BUS_AC;
                            reg_we  = NREG'(1) << f;
                        end
                        OP_LDM: dram_rd = 1'b1;
                        OP_STM: begin
                            bus_sel = BUS_AC;
                            dram_we = 1'b1;
                        end
                        OP_JMP: begin
                            bus_sel = f;
                            pc_ld   = 1'b1;
                        end
                        OP_JMPN: begin
                            bus_sel = f;
                            pc_ld   = neg_q;
                        end
                        OP_JMPL: begin
                            bus_sel = f;
                            pc_ld   = lsb_q;
                        end
                        default: ;
                    endcase
                end
            end
            EXEC2: begin
                alu_sel = f;
                bus_sel = BUS_ALU;
                ac_we   = 1'b1;
            end
            MWAIT: begin
                if (mem_done) begin
                    bus_sel = BUS_DRAM;
                    ac_we   = 1'b1;
                end
            end
            HALT: halt = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: rtl/control_unit.sv
// Multi-cycle fetch/decode/execute sequencer for the 18-bit datapath.
// Holds the FSM, wait counter, IR and ALU flag latches; outputs come from ctrl_decode.
//
// state  | meaning
// IDLE   | one cycle after reset release
// FETCH  | iram_rd + pc_inc strobe
// IWAIT  | waiting IMEM_LAT cycles, IR captured on exit
// DECODE | dispatch on IR class
// EXEC1  | first execute cycle of every non-NOP/HALT class
// EXEC2  | ALU writeback, flags captured on exit
// MWAIT  | waiting DMEM_LAT cycles, AC loaded on last
// HALT   | stopped until reset
module control_unit
    import ctrl_pkg::*;
#(
    parameter int IMEM_LAT = 1,
    parameter int DMEM_LAT = 2,
    parameter int NREG     = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    control_unit_if.master cu
);
    localparam logic [2:0] IMEM_LAST = 3'(IMEM_LAT - 1);
    localparam logic [2:0] DMEM_LAST = 3'(DMEM_LAT - 1);

    state_t     state;
    state_t     state_nxt;
    logic [2:0] cnt;
    logic [7:0] ir;
    logic       neg_q;
    logic       lsb_q;
    logic       iwait_done;
    logic       mwait_done;

    assign iwait_done = (state == IWAIT) && (cnt == IMEM_LAST);
    assign mwait_done = (state == MWAIT) && (cnt == DMEM_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            ir    <= '0;
            neg_q <= 1'b0;
            lsb_q <= 1'b0;
        end else begin
            state <= state_nxt;
            // cnt holds completed cycles in the current wait state
            if ((state_nxt == state) && ((state == IWAIT) || (state == MWAIT)))
                cnt <= cnt + 3'd1;
            else
                cnt <= '0;
            if (iwait_done)
                ir <= cu.iram_data;
            if (state == EXEC2) begin
                neg_q <= cu.neg;
                lsb_q <= cu.lsb;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   state_nxt = FETCH;
            FETCH:  state_nxt = IWAIT;
            IWAIT:  if (iwait_done) state_nxt = DECODE;
            DECODE: begin
                if (ir[7:4] == OP_NOP)
                    state_nxt = FETCH;
                else if (ir[7:4] == OP_HALT)
                    state_nxt = HALT;
                else if (is_defined(ir[7:4]))
                    state_nxt = EXEC1;
                else
                    state_nxt = FETCH;
            end
            EXEC1: begin
                if (ir[7:4] == OP_ALU)
                    state_nxt = EXEC2;
                else if (ir[7:4] == OP_LDM)
                    state_nxt = MWAIT;
                else
                    state_nxt = FETCH;
            end
            EXEC2:  state_nxt = FETCH;
            MWAIT:  if (mwait_done) state_nxt = FETCH;
            HALT:   state_nxt = HALT;
            default: state_nxt = IDLE;
        endcase
    end

    ctrl_decode #(
        .NREG (NREG)
    ) u_decode (
        .state    (state),
        .ir       (ir),
        .neg_q    (neg_q),
        .lsb_q    (lsb_q),
        .mem_done (mwait_done),
        .iram_rd  (cu.iram_rd),
        .pc_inc   (cu.pc_inc),
        .pc_ld    (cu.pc_ld),
        .alu_sel  (cu.alu_sel),
        .bus_sel  (cu.bus_sel),
        .ac_we    (cu.ac_we),
        .reg_we   (cu.reg_we),
        .dram_rd  (cu.dram_rd),
        .dram_we  (cu.dram_we),
        .halt     (cu.halt),
        .illegal  (cu.illegal)
    );
endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: stimulus queues per-cycle expected output
// vectors, a negedge monitor pops and compares them against the DUT.
module tb_control_unit;

    typedef struct {
        int          cyc;
        logic [23:0] v;
        string       nm;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   base;
    int   n_checks;
    int   n_fail;
    exp_t sb[$];
    exp_t mon_e;
    logic [23:0] act;

    control_unit_if #(.NREG(8)) u_if ();

    control_unit #(
        .IMEM_LAT (1),
        .DMEM_LAT (2),
        .NREG     (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .cu    (u_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign act = {u_if.iram_rd, u_if.pc_inc, u_if.pc_ld, u_if.alu_sel, u_if.bus_sel,
                  u_if.ac_we, u_if.reg_we, u_if.dram_rd, u_if.dram_we, u_if.halt,
                  u_if.illegal};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    function automatic logic [23:0] ov(input logic ird, input logic pinc, input logic pld,
                                       input logic [3:0] alu, input logic [3:0] bus,
                                       input logic acw, input logic [7:0] rw,
                                       input logic drd, input logic dwe,
                                       input logic hlt, input logic ill);
        return {ird, pinc, pld, alu, bus, acw, rw, drd, dwe, hlt, ill};
    endfunction

    task automatic check_vec(input string nm, input logic [23:0] a, input logic [23:0] e);
        n_checks++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %06h expected %06h (t=%0t)", nm, a, e, $time);
        end
    endtask

    task automatic push(input int c, input logic [23:0] v, input string nm);
        exp_t e;
        e.cyc = c;
        e.v   = v;
        e.nm  = nm;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                mon_e = sb.pop_front();
                if (mon_e.cyc < cyc) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL %s: cycle %0d never sampled, now at %0d", mon_e.nm, mon_e.cyc, cyc);
                end else begin
                    check_vec(mon_e.nm, act, mon_e.v);
                end
            end
        end
    end

    // Queue one instruction's cycle-by-cycle expectations, then let it run.
    task automatic instr(input string nm, input logic [7:0] ins, input logic n, input logic l,
                         input int len, input logic [23:0] d2, input logic [23:0] e3,
                         input logic [23:0] e4, input logic [23:0] e5);
        logic [23:0] ev [6];
        ev[0] = ov(1, 1, 0, 4'h0, 4'h0, 0, 8'h00, 0, 0, 0, 0);
        ev[1] = '0;
        ev[2] = d2;
        ev[3] = e3;
        ev[4] = e4;
        ev[5] = e5;
        for (int i = 0; i < len; i++)
            push(base + i, ev[i], $sformatf("%s_c%0d", nm, i));
        u_if.iram_data = ins;
        u_if.neg       = n;
        u_if.lsb       = l;
        repeat (len) @(posedge clk);
        #1;
        base += len;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] z;
        z        = '0;
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        u_if.iram_data = 8'h00;
        u_if.neg = 1'b0;
        u_if.lsb = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check_vec("reset_outs", act, z);

        @(posedge clk); #1;
        push(0, z, "idle");
        rst_n = 1'b1;
        @(posedge clk); #1;
        base = 1;

        instr("nop0", 8'h00, 0, 0, 3, z, z, z, z);
        instr("nop1", 8'h00, 0, 0, 3, z, z, z, z);
        instr("alu1_neg", 8'h11, 1, 0, 5, z,
              ov(0,0,0,4'h1,4'h0,0,8'h00,0,0,0,0),
              ov(0,0,0,4'h1,4'hB,1,8'h00,0,0,0,0), z);
        instr("jmpn_taken", 8'h73, 0, 0, 4, z, ov(0,0,1,4'h0,4'h3,0,8'h00,0,0,0,0), z, z);
        instr("alu2_lsb", 8'h12, 0, 1, 5, z,
              ov(0,0,0,4'h2,4'h0,0,8'h00,0,0,0,0),
              ov(0,0,0,4'h2,4'hB,1,8'h00,0,0,0,0), z);
        instr("jmpn_not", 8'h73, 1, 0, 4, z, ov(0,0,0,4'h0,4'h3,0,8'h00,0,0,0,0), z, z);
        instr("jmpl_taken", 8'h85, 0, 0, 4, z, ov(0,0,1,4'h0,4'h5,0,8'h00,0,0,0,0), z, z);
        instr("ldr3", 8'h23, 0, 0, 4, z, ov(0,0,0,4'h0,4'h3,1,8'h00,0,0,0,0), z, z);
        instr("str6", 8'h36, 0, 0, 4, z, ov(0,0,0,4'h0,4'hA,0,8'h40,0,0,0,0), z, z);
        instr("stm", 8'h50, 0, 0, 4, z, ov(0,0,0,4'h0,4'hA,0,8'h00,0,1,0,0), z, z);
        instr("jmp7", 8'h67, 0, 0, 4, z, ov(0,0,1,4'h0,4'h7,0,8'h00,0,0,0,0), z, z);
        instr("ldm", 8'h40, 0, 0, 6, z,
              ov(0,0,0,4'h0,4'h0,0,8'h00,1,0,0,0), z,
              ov(0,0,0,4'h0,4'hC,1,8'h00,0,0,0,0));
        instr("jmpl_persist", 8'h82, 0, 0, 4, z, ov(0,0,1,4'h0,4'h2,0,8'h00,0,0,0,0), z, z);
        instr("ldr_bad", 8'h29, 0, 0, 4, z, ov(0,0,0,4'h0,4'h0,0,8'h00,0,0,0,1), z, z);
        instr("str_bad", 8'h38, 0, 0, 4, z, ov(0,0,0,4'h0,4'h0,0,8'h00,0,0,0,1), z, z);
        instr("jmp_bad", 8'h6F, 0, 0, 4, z, ov(0,0,0,4'h0,4'h0,0,8'h00,0,0,0,1), z, z);
        instr("undef9", 8'h90, 0, 0, 3, ov(0,0,0,4'h0,4'h0,0,8'h00,0,0,0,1), z, z, z);
        instr("undefE", 8'hE0, 0, 0, 3, ov(0,0,0,4'h0,4'h0,0,8'h00,0,0,0,1), z, z, z);

        // ALU op cut short by reset while in EXEC2
        push(base,     ov(1,1,0,4'h0,4'h0,0,8'h00,0,0,0,0), "alu3_fetch");
        push(base + 1, z, "alu3_iwait");
        push(base + 2, z, "alu3_decode");
        push(base + 3, ov(0,0,0,4'h3,4'h0,0,8'h00,0,0,0,0), "alu3_exec1");
        u_if.iram_data = 8'h13;
        u_if.neg = 1'b1;
        u_if.lsb = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        check_vec("exec2_before_reset", act, ov(0,0,0,4'h3,4'hB,1,8'h00,0,0,0,0));
        rst_n = 1'b0;
        #1;
        check_vec("async_drop", act, z);
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        push(0, z, "idle_after_reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        base = 1;

        instr("jmpl_cleared", 8'h81, 0, 0, 4, z, ov(0,0,0,4'h0,4'h1,0,8'h00,0,0,0,0), z, z);
        instr("jmpn_cleared", 8'h71, 0, 0, 4, z, ov(0,0,0,4'h0,4'h1,0,8'h00,0,0,0,0), z, z);

        push(base,     ov(1,1,0,4'h0,4'h0,0,8'h00,0,0,0,0), "halt_fetch");
        push(base + 1, z, "halt_iwait");
        push(base + 2, z, "halt_decode");
        for (int i = 3; i < 25; i++)
            push(base + i, ov(0,0,0,4'h0,4'h0,0,8'h00,0,0,1,0), $sformatf("halt_hold%0d", i));
        u_if.iram_data = 8'hF0;
        repeat (5) @(posedge clk);
        u_if.iram_data = 8'h11;
        u_if.neg = 1'b1;
        repeat (20) @(posedge clk);
        #1;

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Multi-cycle fetch/decode/execute sequencer for the 18-bit datapath.
- Sits directly upstream of the ALU and drives its `alu_sel`.
- Consumes the ALU `neg`/`lsb` flags for conditional jumps.
- Issues all bus-select, register-write, PC and memory strobes.

Parameters:
- IMEM_LAT, 1, instruction-RAM read latency in cycles (range 1..7).
- DMEM_LAT, 2, data-RAM read latency in cycles (range 1..7).
- NREG, 8, number of general registers addressable by `reg_we` and `bus_sel` codes 0..NREG-1 (max 10).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- iram_data  in  8  instruction byte from instruction RAM: [7:4] class, [3:0] field f.
- neg  in  1  ALU negative flag.
- lsb  in  1  ALU result LSB flag.
- iram_rd  out  1  instruction RAM read strobe.
- pc_inc  out  1  PC increment strobe.
- pc_ld  out  1  PC load from bus.
- alu_sel  out  4  ALU operation select.
- bus_sel  out  4  bus source: 0..NREG-1 registers, 0xA AC, 0xB ALU c, 0xC DRAM.
- ac_we  out  1  accumulator write from bus.
- reg_we  out  NREG  one-hot register write from bus.
- dram_rd  out  1  data RAM read strobe.
- dram_we  out  1  data RAM write strobe.
- halt  out  1  processor halted.
- illegal  out  1  one-cycle pulse on an undefined class or an out-of-range register field.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; IR=0; flag latches neg_q/lsb_q=0; wait counter=0.
  - All outputs 0 immediately; strobes drop mid-operation without completing.
- Output timing:
  - Outputs are Moore, decoded from state and IR.
  - Any output not listed as asserted in a state is 0.
- State sequence:
  - IDLE: one cycle after reset release, then FETCH.
  - FETCH: iram_rd=1, pc_inc=1 (one cycle); counter cleared; go to IWAIT.
  - IWAIT: counter counts 1..IMEM_LAT. On the edge leaving the IMEM_LAT-th cycle, IR<=iram_data and go to DECODE.
  - DECODE: dispatch on IR[7:4]:
    - 0x0 NOP: go to FETCH.
    - 0xF HALT: go to HALT.
    - Undefined class: illegal=1, go to FETCH.
    - Any other class: go to EXEC1.
- EXEC1, per class:
  - 0x1 ALU: alu_sel=f; go to EXEC2.
  - 0x2 LDR: bus_sel=f, ac_we=1.
  - 0x3 STR: bus_sel=0xA, reg_we[f]=1.
  - 0x4 LDM: dram_rd=1; go to MWAIT.
  - 0x5 STM: bus_sel=0xA, dram_we=1.
  - 0x6 JMP: bus_sel=f, pc_ld=1.
  - 0x7 JMPN: bus_sel=f; pc_ld=neg_q.
  - 0x8 JMPL: bus_sel=f; pc_ld=lsb_q.
  - Every class except ALU and LDM goes to FETCH after EXEC1.
- EXEC2 (ALU only; the ALU is registered, so its result is valid one cycle after select):
  - alu_sel held at f; bus_sel=0xB; ac_we=1.
  - On the exit edge: neg_q<=neg, lsb_q<=lsb.
  - Go to FETCH.
- MWAIT:
  - Counter counts 1..DMEM_LAT.
  - On the DMEM_LAT-th cycle: bus_sel=0xC, ac_we=1; then go to FETCH.
- HALT: halt=1; all other outputs 0; leaves only via reset.
- Register field check:
  - For LDR, STR, JMP, JMPN and JMPL with f>=NREG: illegal=1 in EXEC1.
  - No write or load strobe is asserted; go to FETCH.
- Flags:
  - neg_q/lsb_q are updated only in ALU EXEC2.
  - They persist across other instructions.
- Latencies at IMEM_LAT=1, DMEM_LAT=2:
  - NOP: 3 cycles.
  - LDR, STR, STM, JMP*: 4 cycles.
  - ALU: 5 cycles.
  - LDM: 6 cycles.
- Counter: 3 bits, cleared on every state entry; no wrap in legal use.

Decomposition:
- Package ctrl_pkg:
  - State enum (IDLE, FETCH, IWAIT, DECODE, EXEC1, EXEC2, MWAIT, HALT).
  - Class opcodes 0x0–0x8 and 0xF.
  - Bus codes BUS_AC=0xA, BUS_ALU=0xB, BUS_DRAM=0xC.
  - ALU_NOP=0.
- One natural sub-module: ctrl_decode, a combinational map from (state, IR, neg_q, lsb_q) to outputs.
- The FSM, counter and IR/flag latches stay in control_unit.

Test Plan:
- Reset release, iram_data=0x00: IDLE 1 cycle, then FETCH with iram_rd=pc_inc=1 for 1 cycle; NOP repeats every 3 cycles; all other outputs 0.
- iram_data=0x11 (ALU sel 1):
  - EXEC1: alu_sel=1.
  - EXEC2: alu_sel=1, bus_sel=0xB, ac_we=1.
  - neg=1 at EXEC2 sets neg_q; the next FETCH follows 5 cycles after the previous one.
- After an ALU op with neg_q=1, instruction 0x73: bus_sel=3, pc_ld=1. With neg_q=0, the same instruction gives pc_ld=0 and bus_sel=3.
- iram_data=0x40, DMEM_LAT=2:
  - dram_rd=1 for 1 cycle.
  - MWAIT for 2 cycles, with bus_sel=0xC, ac_we=1 on the second.
  - Total 6 cycles.
- iram_data=0x29 (NREG=8): illegal=1 in EXEC1, ac_we=0. iram_data=0x90: illegal=1 in DECODE.
- iram_data=0xF0: halt=1 held for 20+ cycles with no strobes. rst_n low during EXEC2 of an ALU op: ac_we drops asynchronously; after release the sequence restarts at IDLE.
